// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Number of bits needed to count 0..v-1 (v >= 2).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Request/result bundle between a controlling FSM and the serial subtractor.
// Latency: n/a (wiring only).
// Backpressure: start is only honoured while busy is low.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    // Controller side: issues requests, observes status and result.
    modport master (
        output start, a, b,
        input  busy, done, diff, bout, ovf
    );

    // Subtractor side.
    modport slave (
        input  start, a, b,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_sub_fs_cell.sv
// Single-bit full subtractor: d = x - y - bin, with borrow out.
// Latency: combinational.
// Backpressure: none.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    // Borrow is taken when y exceeds x, or when they match and a borrow comes in.
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_sub.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full-subtractor cell.
// Latency: start accepted at edge 0, done pulses in the cycle after edge WIDTH.
// Backpressure: start ignored while busy; one op per WIDTH+2 cycles back to back.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_sub_if.slave  bus
);
    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic [CNT_W-1:0] cnt;
    logic             borrow;
    logic             a_msb;
    logic             b_msb;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;

    logic             cell_d;
    logic             cell_bout;

    fs_cell u_cell (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Control FSM and datapath. The result registers are loaded on the edge that
    // enters FIN so they are already valid while done is high, and are otherwise
    // untouched, which keeps partial results off the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            d_sh   <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        a_msb  <= bus.a[WIDTH-1];
                        b_msb  <= bus.b[WIDTH-1];
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    d_sh   <= {cell_d, d_sh[WIDTH-1:1]};
                    borrow <= cell_bout;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        // Final bit: cell_d is the result MSB.
                        diff_q <= {cell_d, d_sh[WIDTH-1:1]};
                        bout_q <= cell_bout;
                        ovf_q  <= (a_msb != b_msb) & (cell_d != a_msb);
                        done_q <= 1'b1;
                        state  <= FIN;
                    end
                end
                FIN: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial N-bit subtractor computing a - b, LSB first, one bit per clock.
- Built around a single-bit full-subtractor cell, with a registered borrow carried between bits.
- Companion to the combinational full-adder datapath: it is the subtract direction, at low area.
- Used where a wide parallel subtractor is not justified; start/busy/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend, captured on accepted start.
- b  input  WIDTH  subtrahend, captured on accepted start.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  a - b modulo 2^WIDTH; held until the next accepted start.
- bout  output  1  final borrow (1 when unsigned a < b); held with diff.
- ovf  output  1  signed two's-complement overflow; held with diff.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; shift registers, borrow flop and bit counter cleared.
- FSM states:
  - IDLE: start=1 loads a/b into shift registers, clears borrow and counter (0..WIDTH-1, ceil(log2 WIDTH) bits), latches a[WIDTH-1] and b[WIDTH-1], and goes to RUN.
  - RUN: each cycle, with x=a_sh[0], y=b_sh[0], br=borrow:
    - d = x^y^br.
    - br_next = (~x&y) | (~(x^y)&br).
    - d is shifted into the diff shift register at the MSB; a_sh and b_sh shift right; the counter increments.
    - When the counter equals WIDTH-1, move to FIN.
  - FIN: diff takes the completed shift register; bout = final borrow; ovf = (a_msb != b_msb) & (diff[WIDTH-1] != a_msb). done=1 for this cycle only. Go to IDLE.
- busy=1 in RUN and FIN; 0 in IDLE.
- Latency: start sampled at edge 0 -> done high in the cycle after edge WIDTH (WIDTH+1 edges total). Back-to-back throughput is one op per WIDTH+2 cycles, because start is honoured only in IDLE.
- start while busy=1: ignored; operands and outputs unaffected.
- diff/bout/ovf change only on the FIN update; they are stable between done pulses and never show partial results.
- a/b may change freely after the start cycle.
- rst_n asserted mid-operation: immediate return to reset values; no done pulse.
- WIDTH edge cases: equal operands give diff=0, bout=0, ovf=0. 0 - max gives 1, bout=1.

Decomposition:
- Shared package holds the FSM state enum (IDLE, RUN, FIN) and the counter width function clog2.
- One sub-module, fs_cell: combinational full subtractor (x, y, bin -> d, bout), the inverse of the full-adder cell. It is instantiated once in the RUN datapath.

Test Plan:
- WIDTH=8, a=0x35, b=0x12, start pulse -> done after 9 edges; diff=0x23, bout=0, ovf=0.
- a=0x12, b=0x35 -> diff=0xDD, bout=1, ovf=0.
- a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1; then a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- a=0x00, b=0x00 -> diff=0x00, bout=0, ovf=0; then a=0x00, b=0xFF -> diff=0x01, bout=1.
- Start a=0x35, b=0x12, then pulse start with a=0xFF, b=0x00 at cycle 3 -> second request ignored; result 0x23; exactly one done.
- Start an operation, assert rst_n=0 at cycle 4 (asynchronous, mid-cycle) -> busy, done, diff, bout and ovf are 0 immediately; no done after release; the next start completes normally.
